// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared constants and helpers for the shift-register link
package shift_reg_pkg;

  localparam int SHREG_DEF_WIDTH = 8;
  localparam bit SHREG_MSB_FIRST = 1'b1;
  localparam bit SHREG_LSB_FIRST = 1'b0;

  // Bit-counter width; never below 1 so the counter port always exists.
  function automatic int shreg_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_reg_rx_core.sv
// rtl/shift_reg_rx_core.sv - serial shift register, bit counter and resync handling
module shift_reg_rx_core
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = SHREG_DEF_WIDTH,
  parameter bit MSB_FIRST = SHREG_MSB_FIRST,
  localparam int CNT_W    = shreg_cnt_w(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_ser_in,
  input  logic             i_ser_valid,
  input  logic             i_sync,
  output logic             o_word_done,
  output logic [WIDTH-1:0] o_word,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] w_count_base;

  // A sync on the same edge as a strobe makes that bit the first of a fresh word.
  always_comb begin
    w_base       = i_sync ? '0 : r_shift;
    w_count_base = i_sync ? '0 : r_count;
    if (MSB_FIRST) begin
      w_shift_nxt = {w_base[WIDTH-2:0], i_ser_in};
    end else begin
      w_shift_nxt = {i_ser_in, w_base[WIDTH-1:1]};
    end
    o_word_done = i_ser_valid && !i_sync && (r_count == LAST_BIT);
    o_word      = w_shift_nxt;
    o_bit_count = r_count;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_ser_valid) begin
      r_shift <= w_shift_nxt;
      r_count <= o_word_done ? '0 : w_count_base + CNT_W'(1);
    end else if (i_sync) begin
      r_shift <= '0;
      r_count <= '0;
    end
  end

endmodule

// File: rtl/shift_reg_rx.sv
// rtl/shift_reg_rx.sv - serial-in/parallel-out receiver with valid/ready holding register
module shift_reg_rx
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = SHREG_DEF_WIDTH,
  parameter bit MSB_FIRST = SHREG_MSB_FIRST,
  localparam int CNT_W    = shreg_cnt_w(WIDTH)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_ser_in,
  input  logic             i_ser_valid,
  input  logic             i_sync,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  input  logic             i_clr_overrun,
  output logic             o_overrun,
  output logic             o_status,
  output logic [CNT_W-1:0] o_bit_count
);

  logic             w_word_done;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_load;
  logic             w_overrun_nxt;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_status;

  shift_reg_rx_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_ser_in    (i_ser_in),
    .i_ser_valid (i_ser_valid),
    .i_sync      (i_sync),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_bit_count (o_bit_count)
  );

  // A word completing on the accept edge replaces the consumed one with no bubble.
  always_comb begin
    w_accept      = r_valid && i_out_ready;
    w_load        = w_word_done && (!r_valid || w_accept);
    w_overrun_nxt = r_overrun;
    if (w_word_done && r_valid && !w_accept) begin
      w_overrun_nxt = 1'b1;
    end else if (i_clr_overrun) begin
      w_overrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_status  <= 1'b1;
    end else begin
      if (w_load) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      r_overrun <= w_overrun_nxt;
      r_status  <= ~w_overrun_nxt;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_overrun   = r_overrun;
  assign o_status    = r_status;

endmodule

// File: tb/tb_shift_reg_rx.sv
// tb/tb_shift_reg_rx.sv - randomized self-checking bench for shift_reg_rx (both bit orders)
module tb_shift_reg_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ser_in = 1'b0;
  logic         ser_valid = 1'b0;
  logic         sync = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_ovr = 1'b0;

  logic [W-1:0] m_data, l_data;
  logic         m_valid, l_valid, m_ovr, l_ovr, m_stat, l_stat;
  logic [2:0]   m_cnt, l_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit           q_bits[$];
  logic [W-1:0] e_msb, e_lsb;
  bit           e_valid, e_ovr;

  always #5 clk = ~clk;

  shift_reg_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .i_clock(clk), .i_reset(rst), .i_ser_in(ser_in), .i_ser_valid(ser_valid),
    .i_sync(sync), .o_out_data(m_data), .o_out_valid(m_valid), .i_out_ready(out_ready),
    .i_clr_overrun(clr_ovr), .o_overrun(m_ovr), .o_status(m_stat), .o_bit_count(m_cnt)
  );

  shift_reg_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .i_clock(clk), .i_reset(rst), .i_ser_in(ser_in), .i_ser_valid(ser_valid),
    .i_sync(sync), .o_out_data(l_data), .o_out_valid(l_valid), .i_out_ready(out_ready),
    .i_clr_overrun(clr_ovr), .o_overrun(l_ovr), .o_status(l_stat), .o_bit_count(l_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the specification's rules, compare.
  task automatic step(input bit b, input bit v, input bit s, input bit rdy, input bit clr,
                      input bit r);
    bit           accept, done, dropped;
    logic [W-1:0] w_msb, w_lsb;
    ser_in = b; ser_valid = v; sync = s; out_ready = rdy; clr_ovr = clr; rst = r;
    @(posedge clk);
    done = 0; dropped = 0; w_msb = '0; w_lsb = '0;
    if (r) begin
      q_bits.delete();
      e_msb = '0; e_lsb = '0; e_valid = 0; e_ovr = 0;
    end else begin
      accept = e_valid && rdy;
      if (s) q_bits.delete();
      if (v) begin
        q_bits.push_back(b);
        if (q_bits.size() == W) begin
          done = 1;
          for (int i = 0; i < W; i++) begin
            w_msb[W-1-i] = q_bits[i];
            w_lsb[i]     = q_bits[i];
          end
          q_bits.delete();
        end
      end
      if (done && (!e_valid || accept)) begin
        e_msb = w_msb; e_lsb = w_lsb; e_valid = 1;
      end else begin
        if (done) dropped = 1;
        if (accept) e_valid = 0;
      end
      if (dropped) e_ovr = 1;
      else if (clr) e_ovr = 0;
    end
    #1;
    check("msb_data",   32'(m_data),   32'(e_msb));
    check("lsb_data",   32'(l_data),   32'(e_lsb));
    check("msb_valid",  32'(m_valid),  32'(e_valid));
    check("lsb_valid",  32'(l_valid),  32'(e_valid));
    check("msb_ovr",    32'(m_ovr),    32'(e_ovr));
    check("lsb_ovr",    32'(l_ovr),    32'(e_ovr));
    check("msb_status", 32'(m_stat),   32'(!e_ovr));
    check("lsb_status", 32'(l_stat),   32'(!e_ovr));
    check("msb_count",  32'(m_cnt),    32'(q_bits.size()));
    check("lsb_count",  32'(l_cnt),    32'(q_bits.size()));
  endtask

  // Send a word MSB-first on consecutive cycles; rdy_last applies only on the final bit.
  task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      step(w[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // reset held two cycles
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    check("rst_valid",  32'(m_valid), 32'd0);
    check("rst_data",   32'(m_data),  32'd0);
    check("rst_ovr",    32'(m_ovr),   32'd0);
    check("rst_status", 32'(m_stat),  32'd1);
    check("rst_count",  32'(m_cnt),   32'd0);

    // basic word in both bit orders
    send_word(8'hC1, 1'b1, 1'b1);
    check("c1_msb_data", 32'(m_data), 32'hC1);
    check("c1_lsb_data", 32'(l_data), 32'h83);
    check("c1_valid",    32'(m_valid), 32'd1);
    step(0, 0, 0, 1, 0, 0);
    check("c1_valid_drop", 32'(m_valid), 32'd0);

    // overrun with consumer stalled, then clear
    send_word(8'hC1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    check("ovr_hold_data", 32'(m_data), 32'hC1);
    check("ovr_set",       32'(m_ovr),  32'd1);
    check("ovr_status",    32'(m_stat), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    check("ovr_clr",        32'(m_ovr),  32'd0);
    check("ovr_clr_status", 32'(m_stat), 32'd1);

    // back-to-back: accept on the completing edge
    step(0, 0, 0, 0, 0, 1);
    send_word(8'hC1, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b1);
    check("b2b_data",  32'(m_data),  32'h5A);
    check("b2b_valid", 32'(m_valid), 32'd1);
    check("b2b_ovr",   32'(m_ovr),   32'd0);

    // resync mid-word, sync and strobe together
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    check("sync_count", 32'(m_cnt), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    check("sync_data", 32'(m_data), 32'h81);

    // reset with partial word and held word
    send_word(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
    check("pre_rst_count", 32'(m_cnt), 32'd5);
    step(0, 0, 0, 0, 0, 1);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data",  32'(m_data),  32'd0);
    check("mid_rst_count", 32'(m_cnt),   32'd0);
    send_word(8'hA7, 1'b1, 1'b1);
    check("post_rst_data", 32'(m_data), 32'hA7);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
